data_mem_sized: RTL and testbench

Parametrised byte-addressed data memory for the multicycle CPU datapath, successor to the fixed 256-byte word-only memory. Supports byte, halfword and word accesses, with sign or zero extension on loads. Every access goes through a request/ready handshake with a configurable wait-state count. Misaligned, out-of-range and illegal-size accesses are detected and reported instead of silently corrupting memory.

---
 rtl/data_mem_sized_if.sv | 24 ++
 rtl/data_mem_sized.sv | 171 +++++++++++++++++
 tb/tb_data_mem_sized.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_sized_if.sv
// Request/response bus of the sized data memory.
// The master drives the access, the slave answers with Busy/Ready/Error/DataOut.
interface data_mem_sized_if;
    logic        Req;
    logic        RW;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Addr;
    logic [31:0] DataIn;
    logic        Busy;
    logic        Ready;
    logic        Error;
    logic [31:0] DataOut;

    modport master (
        output Req, RW, Size, Unsigned, Addr, DataIn,
        input  Busy, Ready, Error, DataOut
    );

    modport slave (
        input  Req, RW, Size, Unsigned, Addr, DataIn,
        output Busy, Ready, Error, DataOut
    );
endinterface

// File: rtl/data_mem_sized.sv
// Byte-addressed data memory with byte/half/word access, load extension,
// wait states and rejection of misaligned, out-of-range or illegal accesses.
module data_mem_sized #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            CLK,
    input  logic            Reset,
    data_mem_sized_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_rw;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_din;
    logic [31:0] r_dout;
    logic        r_err;
    logic [7:0]  r_mem [0:DEPTH-1] = '{default: 8'h00};

    logic                  w_accept;
    logic                  w_exec;
    logic                  w_rw;
    logic                  w_uns;
    logic                  w_err;
    logic                  w_busy;
    logic                  w_ready;
    logic [1:0]            w_size;
    logic [31:0]           w_addr;
    logic [31:0]           w_din;
    logic [31:0]           w_load;
    logic [ADDR_WIDTH-1:0] w_i0;
    logic [ADDR_WIDTH-1:0] w_i1;
    logic [ADDR_WIDTH-1:0] w_i2;
    logic [ADDR_WIDTH-1:0] w_i3;
    logic [7:0]            w_b0;
    logic [7:0]            w_b1;
    logic [7:0]            w_b2;
    logic [7:0]            w_b3;

    // With no wait states the access executes at the accept edge itself,
    // so the live inputs are the operands; otherwise the captured copy is.
    assign w_rw   = (WAIT_CYCLES == 0) ? bus.RW       : r_rw;
    assign w_uns  = (WAIT_CYCLES == 0) ? bus.Unsigned : r_uns;
    assign w_size = (WAIT_CYCLES == 0) ? bus.Size     : r_size;
    assign w_addr = (WAIT_CYCLES == 0) ? bus.Addr     : r_addr;
    assign w_din  = (WAIT_CYCLES == 0) ? bus.DataIn   : r_din;

    assign w_accept = bus.Req && (r_state != S_WAIT);
    assign w_exec   = !Reset && ((WAIT_CYCLES == 0) ? w_accept :
                      (r_state == S_WAIT && r_cnt == 4'd0));

    assign w_i0 = w_addr[ADDR_WIDTH-1:0];
    assign w_i1 = w_i0 + ADDR_WIDTH'(1);
    assign w_i2 = w_i0 + ADDR_WIDTH'(2);
    assign w_i3 = w_i0 + ADDR_WIDTH'(3);
    assign w_b0 = r_mem[w_i0];
    assign w_b1 = r_mem[w_i1];
    assign w_b2 = r_mem[w_i2];
    assign w_b3 = r_mem[w_i3];

    // Reject illegal size, misalignment and addresses beyond the array.
    always_comb begin
        w_err = (w_addr >> ADDR_WIDTH) != 32'd0;
        case (w_size)
            2'b00:   ;
            2'b01:   if (w_addr[0]) w_err = 1'b1;
            2'b10:   if (w_addr[1:0] != 2'b00) w_err = 1'b1;
            default: w_err = 1'b1;
        endcase
    end

    // Assemble the load result with sign or zero extension.
    always_comb begin
        w_load = 32'd0;
        case (w_size)
            2'b00:   w_load = {{24{~w_uns & w_b0[7]}}, w_b0};
            2'b01:   w_load = {{16{~w_uns & w_b1[7]}}, w_b1, w_b0};
            2'b10:   w_load = {w_b3, w_b2, w_b1, w_b0};
            default: w_load = 32'd0;
        endcase
    end

    // Store lanes at the execute edge; the array is never reset.
    always_ff @(posedge CLK) begin
        if (w_exec && !w_err && w_rw) begin
            r_mem[w_i0] <= w_din[7:0];
            if (w_size != 2'b00) begin
                r_mem[w_i1] <= w_din[15:8];
            end
            if (w_size == 2'b10) begin
                r_mem[w_i2] <= w_din[23:16];
                r_mem[w_i3] <= w_din[31:24];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a request in RESP starts the next access at once.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_RESP: begin
                if (bus.Req) begin
                    w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        w_busy  = (r_state == S_WAIT);
        w_ready = (r_state == S_RESP);
    end

    // Capture the access at accept and count down the wait states.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_cnt  <= 4'd0;
            r_rw   <= 1'b0;
            r_uns  <= 1'b0;
            r_size <= 2'b00;
            r_addr <= 32'd0;
            r_din  <= 32'd0;
        end else if (w_accept) begin
            r_cnt  <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
            r_rw   <= bus.RW;
            r_uns  <= bus.Unsigned;
            r_size <= bus.Size;
            r_addr <= bus.Addr;
            r_din  <= bus.DataIn;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response registers hold until the next execute edge.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_err  <= 1'b0;
            r_dout <= 32'd0;
        end else if (w_exec) begin
            r_err  <= w_err;
            r_dout <= (w_err || w_rw) ? 32'd0 : w_load;
        end
    end

    assign bus.Busy    = w_busy;
    assign bus.Ready   = w_ready;
    assign bus.Error   = r_err;
    assign bus.DataOut = r_dout;
endmodule

// File: tb/tb_data_mem_sized.sv
// Directed bench for data_mem_sized at WAIT_CYCLES 1, 0 and 3 with a
// response scoreboard and immediate assertions at each comparison.
module tb_data_mem_sized;
    logic        clk;
    logic        rst;
    logic        req;
    logic        rw;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] din;
    int          sel;
    logic        o_busy;
    logic        o_ready;
    logic        o_err;
    logic [31:0] o_dout;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [32:0] sb[$];
    int          wc_of[3] = '{1, 0, 3};
    logic [31:0] last_dout[3] = '{32'd0, 32'd0, 32'd0};

    data_mem_sized_if bus1 ();
    data_mem_sized_if bus0 ();
    data_mem_sized_if bus3 ();

    assign bus1.Req = req && (sel == 0);
    assign bus0.Req = req && (sel == 1);
    assign bus3.Req = req && (sel == 2);
    assign bus1.RW = rw;
    assign bus0.RW = rw;
    assign bus3.RW = rw;
    assign bus1.Size = size;
    assign bus0.Size = size;
    assign bus3.Size = size;
    assign bus1.Unsigned = uns;
    assign bus0.Unsigned = uns;
    assign bus3.Unsigned = uns;
    assign bus1.Addr = addr;
    assign bus0.Addr = addr;
    assign bus3.Addr = addr;
    assign bus1.DataIn = din;
    assign bus0.DataIn = din;
    assign bus3.DataIn = din;

    data_mem_sized #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_w1 (
        .CLK(clk), .Reset(rst), .bus(bus1.slave));
    data_mem_sized #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_w0 (
        .CLK(clk), .Reset(rst), .bus(bus0.slave));
    data_mem_sized #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) u_w3 (
        .CLK(clk), .Reset(rst), .bus(bus3.slave));

    always_comb begin
        o_busy  = bus1.Busy;
        o_ready = bus1.Ready;
        o_err   = bus1.Error;
        o_dout  = bus1.DataOut;
        if (sel == 1) begin
            o_busy  = bus0.Busy;
            o_ready = bus0.Ready;
            o_err   = bus0.Error;
            o_dout  = bus0.DataOut;
        end else if (sel == 2) begin
            o_busy  = bus3.Busy;
            o_ready = bus3.Ready;
            o_err   = bus3.Error;
            o_dout  = bus3.DataOut;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access: drive, push the expected response, scramble the inputs
    // after accept, then wait for Ready and compare latency and response.
    task automatic acc(input string tag, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] d, input logic e_err,
                       input logic [31:0] e_dout);
        int cyc;
        int nb;
        logic [32:0] ex;
        @(negedge clk);
        req = 1'b1;
        rw = w;
        size = sz;
        uns = u;
        addr = a;
        din = d;
        sb.push_back({e_err, e_dout});
        @(posedge clk);
        #1;
        req = 1'b0;
        rw = ~w;
        uns = ~u;
        size = 2'($urandom);
        addr = $urandom;
        din = $urandom;
        cyc = 0;
        nb = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            chk({tag, "/rdy_busy"}, {31'd0, o_ready & o_busy}, 32'd0);
            if (o_ready) break;
            if (o_busy) nb++;
            chk({tag, "/hold"}, o_dout, last_dout[sel]);
        end
        chk({tag, "/lat"}, cyc, wc_of[sel] + 1);
        chk({tag, "/busy"}, nb, wc_of[sel]);
        ex = (sb.size() > 0) ? sb.pop_front() : 33'h1_DEAD_DEAD;
        chk({tag, "/err"}, {31'd0, o_err}, {31'd0, ex[32]});
        chk({tag, "/dout"}, o_dout, ex[31:0]);
        last_dout[sel] = ex[31:0];
    endtask

    initial begin
        int nrdy;
        int first;
        logic [32:0] ex;
        rst = 1'b0;
        req = 1'b0;
        rw = 1'b0;
        size = 2'b00;
        uns = 1'b0;
        addr = 32'd0;
        din = 32'd0;
        sel = 0;
        #3 rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst/busy", {31'd0, o_busy}, 32'd0);
            chk("rst/ready", {31'd0, o_ready}, 32'd0);
            chk("rst/err", {31'd0, o_err}, 32'd0);
            chk("rst/dout", o_dout, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        sel = 0;

        acc("w1_wr", 1, 2'b10, 0, 32'h10, 32'hA1B2C3D4, 0, 32'h0);
        acc("w1_rd", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hA1B2C3D4);
        acc("sb10", 0, 2'b00, 0, 32'h10, 32'h0, 0, 32'hFFFFFFD4);
        acc("sb11", 0, 2'b00, 0, 32'h11, 32'h0, 0, 32'hFFFFFFC3);
        acc("sb12", 0, 2'b00, 0, 32'h12, 32'h0, 0, 32'hFFFFFFB2);
        acc("sb13", 0, 2'b00, 0, 32'h13, 32'h0, 0, 32'hFFFFFFA1);
        acc("ub13", 0, 2'b00, 1, 32'h13, 32'h0, 0, 32'h000000A1);
        acc("ub10", 0, 2'b00, 1, 32'h10, 32'h0, 0, 32'h000000D4);
        acc("sh12", 0, 2'b01, 0, 32'h12, 32'h0, 0, 32'hFFFFA1B2);
        acc("uh10", 0, 2'b01, 1, 32'h10, 32'h0, 0, 32'h0000C3D4);
        acc("sh10", 0, 2'b01, 0, 32'h10, 32'h0, 0, 32'hFFFFC3D4);
        acc("hw_mis", 1, 2'b01, 0, 32'h11, 32'h1234, 1, 32'h0);
        acc("rd_after", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hA1B2C3D4);
        acc("rd_range", 0, 2'b10, 0, 32'h100, 32'h0, 1, 32'h0);
        acc("rd_mis", 0, 2'b10, 0, 32'h12, 32'h0, 1, 32'h0);
        acc("sz11", 0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0);
        acc("bw14", 1, 2'b00, 0, 32'h14, 32'hFFFFFF7F, 0, 32'h0);
        acc("rd14", 0, 2'b10, 0, 32'h14, 32'h0, 0, 32'h0000007F);
        acc("hw16", 1, 2'b01, 0, 32'h16, 32'hCAFE8001, 0, 32'h0);
        acc("rd14b", 0, 2'b10, 0, 32'h14, 32'h0, 0, 32'h8001007F);

        // Back-to-back byte stores with no wait states.
        @(negedge clk);
        sel = 1;
        rw = 1'b1;
        size = 2'b00;
        uns = 1'b0;
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h20 + 32'(i);
            din = {24'hABCDEF, 8'(8'h11 * (i + 1))};
            sb.push_back(33'd0);
            @(negedge clk);
            chk("b2b/ready", {31'd0, o_ready}, 32'd1);
            chk("b2b/busy", {31'd0, o_busy}, 32'd0);
            ex = (sb.size() > 0) ? sb.pop_front() : 33'h1_DEAD_DEAD;
            chk("b2b/err", {31'd0, o_err}, {31'd0, ex[32]});
        end
        req = 1'b0;
        last_dout[1] = 32'd0;
        acc("w0_rd", 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h44332211);
        acc("w0_sh", 0, 2'b01, 0, 32'h22, 32'h0, 0, 32'h00004433);

        // Reset in the middle of a three-wait-state store aborts it.
        @(negedge clk);
        sel = 2;
        req = 1'b1;
        rw = 1'b1;
        size = 2'b10;
        addr = 32'h30;
        din = 32'hDEADBEEF;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("abort/busy1", {31'd0, o_busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort/busy", {31'd0, o_busy}, 32'd0);
        chk("abort/ready", {31'd0, o_ready}, 32'd0);
        chk("abort/err", {31'd0, o_err}, 32'd0);
        chk("abort/dout", o_dout, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nrdy = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_ready) nrdy++;
        end
        chk("abort/no_rdy", nrdy, 0);
        last_dout = '{32'd0, 32'd0, 32'd0};
        acc("w3_rd30", 0, 2'b10, 0, 32'h30, 32'h0, 0, 32'h0);
        acc("w3_wr34", 1, 2'b10, 0, 32'h34, 32'h87654321, 0, 32'h0);

        // Requests during WAIT are dropped, not queued.
        @(negedge clk);
        req = 1'b1;
        rw = 1'b0;
        size = 2'b10;
        uns = 1'b0;
        addr = 32'h34;
        sb.push_back({1'b0, 32'h87654321});
        @(posedge clk);
        #1 req = 1'b0;
        nrdy = 0;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (o_ready) begin
                nrdy++;
                if (first == 0) begin
                    first = k;
                    ex = (sb.size() > 0) ? sb.pop_front() : 33'h1_DEAD_DEAD;
                    chk("tog/err", {31'd0, o_err}, {31'd0, ex[32]});
                    chk("tog/dout", o_dout, ex[31:0]);
                end
            end
            req = (k == 1 || k == 3);
            addr = $urandom;
        end
        chk("tog/nrdy", nrdy, 1);
        chk("tog/first", first, 4);
        chk("sb/empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
